// File: rtl/montgomery_mul_radix.sv
// montgomery_mul_radix: iterative radix-2^DIGIT Montgomery multiplier.
// Computes o_result = i_a * i_b * 2^-WIDTH mod i_n, one DIGIT-bit slice of a per cycle.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           one-cycle request, honoured only when idle
//   i_a, i_b, i_n     operands (< i_n) and odd modulus, latched on accept
//   i_n_prime         -i_n^-1 mod 2^DIGIT
//   o_result          result, held until the next accepted start
//   o_finished        one-cycle completion pulse
//   o_busy            request in progress (ITER and FINAL)
//   o_error           with o_finished when an even modulus was rejected

module montgomery_mul_radix #(
    parameter int WIDTH = 256,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    input  logic [DIGIT-1:0] i_n_prime,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished,
    output logic             o_busy,
    output logic             o_error
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = WIDTH + 2;
    localparam int PW = WIDTH + DIGIT;
    localparam int TW = WIDTH + DIGIT + 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ITER  = 3'd1;
    localparam logic [2:0] ST_FINAL = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [DIGIT-1:0] np_q, np_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [DIGIT-1:0] a_dig;
    logic [PW-1:0]    ab_w;
    logic [TW-1:0]    t_w;
    logic [DIGIT-1:0] q_w;
    logic [PW-1:0]    qn_w;
    logic [TW-1:0]    u_w;
    logic             ge_n;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        np_d     = np_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // a is shifted down each iteration, so the current digit is always at the bottom.
        a_dig = a_q[DIGIT-1:0];
        ab_w  = PW'(a_dig) * PW'(b_q);
        t_w   = TW'(s_q) + TW'(ab_w);
        // Truncating multiply: q only needs the low DIGIT bits.
        q_w   = t_w[DIGIT-1:0] * np_q;
        qn_w  = PW'(q_w) * PW'(n_q);
        u_w   = t_w + TW'(qn_w);
        ge_n  = (s_q >= SW'(n_q));

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_n[0]) begin
                        a_d     = i_a;
                        b_d     = i_b;
                        n_d     = i_n;
                        np_d    = i_n_prime;
                        s_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_ITER;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ITER: begin
                // Low DIGIT bits of u_w are zero by choice of q; drop them.
                s_d   = SW'(u_w >> DIGIT);
                a_d   = a_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                // S < 2N, so one conditional subtraction suffices; the
                // extra bits of S keep N = 2^WIDTH-1 from overflowing.
                result_d = ge_n ? WIDTH'(s_q - SW'(n_q)) : s_q[WIDTH-1:0];
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            np_q     <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            np_q     <= np_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_result   = result_q;
    assign o_finished = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign o_busy     = (state_q == ST_ITER) || (state_q == ST_FINAL);
    assign o_error    = (state_q == ST_ERR);

endmodule

// File: tb/tb_montgomery_mul_radix.sv
// tb_montgomery_mul_radix: bench for the radix-2^DIGIT Montgomery multiplier.
// Two instances: 256-bit/DIGIT=4 and 16-bit/DIGIT=1.

module tb_montgomery_mul_radix;

    localparam logic [255:0] P25519 = (256'd1 << 255) - 256'd19;
    localparam logic [255:0] NMAX   = ~256'd0;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] op_a, op_b, op_n;
    logic [3:0]   op_np;
    logic [255:0] result;
    logic         fin, busy, err;

    logic         s_start;
    logic [15:0]  s_a, s_b, s_n;
    logic [0:0]   s_np;
    logic [15:0]  s_result;
    logic         s_fin, s_busy, s_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    montgomery_mul_radix #(.WIDTH(256), .DIGIT(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_a(op_a), .i_b(op_b), .i_n(op_n), .i_n_prime(op_np),
        .o_result(result), .o_finished(fin), .o_busy(busy), .o_error(err)
    );

    montgomery_mul_radix #(.WIDTH(16), .DIGIT(1)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(s_start),
        .i_a(s_a), .i_b(s_b), .i_n(s_n), .i_n_prime(s_np),
        .o_result(s_result), .o_finished(s_fin), .o_busy(s_busy), .o_error(s_err)
    );

    typedef struct {
        string        name;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] n;
        logic [3:0]   np;
        logic [255:0] exp;
    } vec_t;

    vec_t tbl[6];

    // a*b*2^-w mod n: reduce the product, then halve w times modulo the odd n.
    function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] n, input int w);
        logic [511:0] x, nn;
        nn = {256'd0, n};
        x  = ({256'd0, a} * {256'd0, b}) % nn;
        for (int i = 0; i < w; i++) begin
            if (x[0]) x = (x + nn) >> 1;
            else      x = x >> 1;
        end
        return x[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Starts one request in the next cycle, returns at the negedge where o_finished is seen.
    task automatic big_op(input logic [255:0] xa, input logic [255:0] xb,
                          input logic [255:0] xn, input logic [3:0] xnp,
                          output logic [255:0] r, output int lat, output bit e,
                          output int bad_busy, output int acc);
        @(negedge clk);
        op_a = xa; op_b = xb; op_n = xn; op_np = xnp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        op_a = ~xa; op_b = ~xb; op_n = ~xn; op_np = ~xnp;
        lat = 1;
        bad_busy = 0;
        while (!fin && lat < 200) begin
            if (!busy) bad_busy++;
            @(negedge clk);
            lat++;
        end
        if (busy) bad_busy++;
        e = err;
        r = result;
    endtask

    task automatic small_op(input logic [15:0] xa, input logic [15:0] xb,
                            output logic [15:0] r, output int lat);
        @(negedge clk);
        s_a = xa; s_b = xb; s_n = 16'hFFF1; s_np = 1'b1; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_a = ~xa; s_b = ~xb;
        lat = 1;
        while (!s_fin && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = s_result;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] r, ra, rb, last_exp, e_ref;
        logic [511:0] chk_mul;
        logic [15:0]  r16, a16, b16;
        int lat, bad, acc, prev_acc, fins;
        bit e;

        tbl[0] = '{"identity",   256'd38, 256'd38,     P25519, 4'd11, 256'd38};
        tbl[1] = '{"conversion", 256'd38, 256'h1234,   P25519, 4'd11, 256'h1234};
        tbl[2] = '{"zero_a",     256'd0,  P25519 - 1,  P25519, 4'd11, 256'd0};
        tbl[3] = '{"zero_b",     256'd5,  256'd0,      P25519, 4'd11, 256'd0};
        tbl[4] = '{"sq_minus1",  P25519 - 1, P25519 - 1, P25519, 4'd11,
                   ref_mont(P25519 - 1, P25519 - 1, P25519, 256)};
        tbl[5] = '{"nmax",       NMAX - 2, NMAX - 1,   NMAX,   4'd1,
                   ref_mont(NMAX - 2, NMAX - 1, NMAX, 256)};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_n = '0; op_np = '0;
        s_start = 1'b0; s_a = '0; s_b = '0; s_n = '0; s_np = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, '0);
        chk("reset_flags", {253'd0, fin, busy, err}, '0);
        chk("reset_result16", {240'd0, s_result}, '0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            big_op(tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].np, r, lat, e, bad, acc);
            chk({tbl[i].name, "_result"}, r, tbl[i].exp);
            chk_int({tbl[i].name, "_latency"}, lat, 66);
            chk_int({tbl[i].name, "_busy"}, bad, 0);
            chk_int({tbl[i].name, "_error"}, int'(e), 0);
        end

        // Square of -1 must be R^-1: r*R == 1 with R mod N = 38.
        big_op(P25519 - 1, P25519 - 1, P25519, 4'd11, r, lat, e, bad, acc);
        chk_mul = ({256'd0, r} * 512'd38) % {256'd0, P25519};
        chk("sq_minus1_inverse", chk_mul[255:0], 256'd1);

        prev_acc = 0;
        for (int i = 0; i < 400; i++) begin
            ra = rnd256() % P25519;
            rb = rnd256() % P25519;
            big_op(ra, rb, P25519, 4'd11, r, lat, e, bad, acc);
            last_exp = ref_mont(ra, rb, P25519, 256);
            chk("rand_result", r, last_exp);
            chk_int("rand_latency", lat, 66);
            if (i > 0) chk_int("rand_period", acc - prev_acc, 67);
            prev_acc = acc;
        end

        big_op(256'd5, 256'd7, {P25519[255:8], 8'hEC}, 4'd11, r, lat, e, bad, acc);
        chk_int("even_latency", lat, 1);
        chk_int("even_error", int'(e), 1);
        chk("even_result_held", r, last_exp);
        chk_int("even_busy", bad, 0);
        big_op(256'd1234, 256'd5678, P25519, 4'd11, r, lat, e, bad, acc);
        chk("after_err_result", r, ref_mont(256'd1234, 256'd5678, P25519, 256));
        chk_int("after_err_error", int'(e), 0);

        ra = rnd256() % P25519;
        rb = rnd256() % P25519;
        @(negedge clk);
        op_a = ra; op_b = rb; op_n = P25519; op_np = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fins = 0; lat = 0; r = '0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 10) begin
                op_a = 256'd3; op_b = 256'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (fin) begin
                fins++;
                if (fins == 1) begin
                    lat = c;
                    r = result;
                end
            end
            @(negedge clk);
        end
        chk_int("busy_start_finishes", fins, 1);
        chk_int("busy_start_latency", lat, 66);
        chk("busy_start_result", r, ref_mont(ra, rb, P25519, 256));

        @(negedge clk);
        op_a = 256'd77; op_b = 256'd99; op_n = P25519; op_np = 4'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_result", result, '0);
        chk("midreset_flags", {253'd0, fin, busy, err}, '0);
        fins = 0;
        for (int c = 0; c < 100; c++) begin
            if (fin) fins++;
            @(negedge clk);
        end
        chk_int("midreset_no_finish", fins, 0);
        big_op(256'd77, 256'd99, P25519, 4'd11, r, lat, e, bad, acc);
        chk("midreset_next_result", r, ref_mont(256'd77, 256'd99, P25519, 256));
        chk_int("midreset_next_latency", lat, 66);

        small_op(16'hFFF0, 16'hFFF0, r16, lat);
        e_ref = ref_mont(256'hFFF0, 256'hFFF0, 256'hFFF1, 16);
        chk("w16_corner_result", {240'd0, r16}, e_ref);
        chk_int("w16_corner_latency", lat, 18);
        for (int i = 0; i < 150; i++) begin
            a16 = 16'($urandom_range(0, 32'hFFF0));
            b16 = 16'($urandom_range(0, 32'hFFF0));
            small_op(a16, b16, r16, lat);
            e_ref = ref_mont({240'd0, a16}, {240'd0, b16}, 256'hFFF1, 16);
            chk("w16_result", {240'd0, r16}, e_ref);
            chk_int("w16_latency", lat, 18);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
